// File: rtl/tinyalu_pkg.sv
// Shared TinyALU types: operation codes, arbiter FSM states, request payload.
// No ports; imported by the arbiter and its grant sub-module.
package tinyalu_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned OP_W   = 3;
  localparam int unsigned RES_W  = 16;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [OP_W-1:0] {
    no_op  = 3'd0,
    add_op = 3'd1,
    and_op = 3'd2,
    xor_op = 3'd3,
    mul_op = 3'd4
  } operation_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // One captured operation as presented to the ALU.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
  } alu_req_t;

  // True for codes the ALU actually executes (no_op and 5..7 excluded).
  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    return (op >= OP_W'(add_op)) && (op <= OP_W'(mul_op));
  endfunction

endpackage

// File: rtl/tinyalu_rr_grant.sv
// Two-requester round-robin grant.
//   valid_i          requester valids {req1, req0}
//   last_grant_i     index granted on the previous accept
//   update_i         accept strobe for this cycle
//   grant_c          one-hot grant (combinational)
//   last_grant_nxt_c value to load into the last-grant register
import tinyalu_pkg::*;

module tinyalu_rr_grant (
  input  logic [1:0] valid_i,
  input  logic       last_grant_i,
  input  logic       update_i,
  output logic [1:0] grant_c,
  output logic       last_grant_nxt_c
);

  // On a tie the requester that did not win last time goes first.
  always_comb begin
    grant_c = 2'b00;
    unique case (valid_i)
      2'b01:   grant_c = 2'b01;
      2'b10:   grant_c = 2'b10;
      2'b11:   grant_c = last_grant_i ? 2'b01 : 2'b10;
      default: grant_c = 2'b00;
    endcase
  end

  assign last_grant_nxt_c = update_i ? grant_c[1] : last_grant_i;

endmodule

// File: rtl/tinyalu_arbiter.sv
// Shares one TinyALU between two requesters with round-robin arbitration.
//   clk, reset_n                   clock, async active-low reset
//   reqN_valid/ready/A/B/op        request channel N (ready is combinational)
//   rspN_valid/ready/result/err    response channel N (registered)
//   alu_A/B/op/start               ALU command (registered)
//   alu_done/alu_result            ALU completion pulse and result
import tinyalu_pkg::*;

module tinyalu_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_A,
  input  logic [DATA_W-1:0] req0_B,
  input  logic [OP_W-1:0]   req0_op,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_A,
  input  logic [DATA_W-1:0] req1_B,
  input  logic [OP_W-1:0]   req1_op,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [RES_W-1:0]  rsp0_result,
  output logic              rsp0_err,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp1_result,
  output logic              rsp1_err,
  output logic [DATA_W-1:0] alu_A,
  output logic [DATA_W-1:0] alu_B,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  input  logic [RES_W-1:0]  alu_result
);

  // Abort in the TIMEOUT_CYCLES-th BUSY cycle, so start is high at most
  // TIMEOUT_CYCLES cycles; a done in that same cycle still wins.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  arb_state_t                 state_q, state_d;
  alu_req_t                   req_q, req_d;
  logic                       owner_q, owner_d;
  logic                       last_grant_q, last_grant_d;
  logic [CNT_W-1:0]           cnt_q, cnt_d;
  logic                       start_q, start_d;
  logic [1:0]                 rsp_valid_q, rsp_valid_d;
  logic [1:0]                 rsp_err_q, rsp_err_d;
  logic [1:0][RES_W-1:0]      rsp_result_q, rsp_result_d;

  logic [1:0] grant_c;
  logic       accept_c;
  logic       acc_idx_c;
  alu_req_t   sel_req_c;
  logic [1:0] rsp_ready_c;

  tinyalu_rr_grant u_grant (
    .valid_i          ({req1_valid, req0_valid}),
    .last_grant_i     (last_grant_q),
    .update_i         (accept_c),
    .grant_c          (grant_c),
    .last_grant_nxt_c (last_grant_d)
  );

  assign accept_c    = (state_q == IDLE) && (grant_c != 2'b00);
  assign req0_ready  = accept_c & grant_c[0];
  assign req1_ready  = accept_c & grant_c[1];
  assign acc_idx_c   = grant_c[1];
  assign sel_req_c   = acc_idx_c ? {req1_A, req1_B, req1_op} : {req0_A, req0_B, req0_op};
  assign rsp_ready_c = {rsp1_ready, rsp0_ready};

  // Next-state and register updates.
  always_comb begin
    state_d      = state_q;
    req_d        = req_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    start_d      = start_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_err_d    = rsp_err_q;
    rsp_result_d = rsp_result_q;

    unique case (state_q)
      IDLE: begin
        if (accept_c) begin
          req_d   = sel_req_c;
          owner_d = acc_idx_c;
          // no_op is swallowed here: captured, never issued, no response.
          if (sel_req_c.op != no_op) begin
            if (op_is_alu(sel_req_c.op)) begin
              state_d = BUSY;
              cnt_d   = '0;
              start_d = 1'b1;
            end else begin
              state_d                 = RESP;
              rsp_valid_d[acc_idx_c]  = 1'b1;
              rsp_result_d[acc_idx_c] = '0;
              rsp_err_d[acc_idx_c]    = 1'b1;
            end
          end
        end
      end

      BUSY: begin
        if (alu_done) begin
          state_d               = RESP;
          start_d               = 1'b0;
          rsp_valid_d[owner_q]  = 1'b1;
          rsp_result_d[owner_q] = alu_result;
          rsp_err_d[owner_q]    = 1'b0;
        end else if (cnt_q == CNT_LAST) begin
          state_d               = RESP;
          start_d               = 1'b0;
          rsp_valid_d[owner_q]  = 1'b1;
          rsp_result_d[owner_q] = '0;
          rsp_err_d[owner_q]    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      RESP: begin
        // Clear the owner's channel on handoff so idle channels read as 0.
        if (rsp_valid_q[owner_q] && rsp_ready_c[owner_q]) begin
          state_d               = IDLE;
          rsp_valid_d[owner_q]  = 1'b0;
          rsp_result_d[owner_q] = '0;
          rsp_err_d[owner_q]    = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State registers; reset discards any pending op or held response.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      req_q        <= '0;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      start_q      <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_err_q    <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      start_q      <= start_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_result_q <= rsp_result_d;
    end
  end

  assign alu_A       = req_q.a;
  assign alu_B       = req_q.b;
  assign alu_op      = req_q.op;
  assign alu_start   = start_q;
  assign rsp0_valid  = rsp_valid_q[0];
  assign rsp1_valid  = rsp_valid_q[1];
  assign rsp0_err    = rsp_err_q[0];
  assign rsp1_err    = rsp_err_q[1];
  assign rsp0_result = rsp_result_q[0];
  assign rsp1_result = rsp_result_q[1];

endmodule
